// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the future receiver).
// UART_TX_BREAK_EN adds the StBreak state used for line-break support.
package uart_pkg;

   // Line states of the transmitter; StBreak exists only with break support.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StGuard
`ifdef UART_TX_BREAK_EN
      ,
      StBreak
`endif
   } tx_state_e;

   // Parity modes.
   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   // Parity bit for a word whose XOR-reduction is word_xor.
   function automatic logic parity_bit(input int unsigned mode, input logic word_xor);
      return (mode == PAR_ODD) ? ~word_xor : word_xor;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Source-side handshake and line signals of the UART transmitter.
// UART_TX_BREAK_EN adds the brk request.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic                 en;
   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 busy;
   logic                 done;
   logic                 out;
`ifdef UART_TX_BREAK_EN
   logic                 brk;
`endif

   // Word source / controller side.
   modport master (
`ifdef UART_TX_BREAK_EN
      output brk,
`endif
      output en,
      output in_data,
      output in_valid,
      input  in_ready,
      input  busy,
      input  done,
      input  out
   );

   // Transmitter side.
   modport slave (
`ifdef UART_TX_BREAK_EN
      input  brk,
`endif
      input  en,
      input  in_data,
      input  in_valid,
      output in_ready,
      output busy,
      output done,
      output out
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LastCnt);

   // Advance the divider; restart holds it at zero, terminal count wraps it.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   // Divider register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// STOP_BITS stop periods and an optional guard period, valid/ready input.
// Define UART_TX_BREAK_EN to add line-break support through bus.brk.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned TURBO_FRAMES = 0
) (
   input logic            clk,
   input logic            rst_n,
   uart_tx_frame_if.slave bus
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (TURBO_FRAMES > 1) begin : g_bad_turbo
      $error("uart_tx_frame: TURBO_FRAMES must be 0 or 1");
   end

   // Wide enough for both the data-bit and stop-bit index.
   localparam int unsigned CntW = 4;
   localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);
   localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);
   localparam bit HasParity = (PARITY != PAR_NONE);
   localparam bit Turbo     = (TURBO_FRAMES == 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 tick;
   logic                 restart;
   logic                 accept;
   logic                 brk;
   logic                 last_stop_tc;

`ifdef UART_TX_BREAK_EN
   assign brk = bus.brk && bus.en;
`else
   assign brk = 1'b0;
`endif

   assign last_stop_tc = (state_q == StStop) && (bit_cnt_q == LastStop) && tick;

   assign bus.in_ready = rst_n && bus.en && !brk &&
                         ((state_q == StIdle) || (Turbo && last_stop_tc));
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.done     = last_stop_tc && bus.en;

   // Hold the divider at zero while nothing is being timed.  In StBreak it is
   // released in the cycle brk drops, so that cycle counts towards the guard.
`ifdef UART_TX_BREAK_EN
   assign restart = !bus.en || (state_q == StIdle) || ((state_q == StBreak) && brk);
`else
   assign restart = !bus.en || (state_q == StIdle);
`endif

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(restart),
      .tick   (tick)
   );

   // Frame sequencing: next state, word capture and bit index.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StStart;
               data_d    = bus.in_data;
               shift_d   = bus.in_data;
               bit_cnt_d = '0;
            end
`ifdef UART_TX_BREAK_EN
            else if (brk) begin
               state_d = StBreak;
            end
`endif
         end
         StStart: begin
            if (tick) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LastData) begin
                  bit_cnt_d = '0;
                  state_d   = HasParity ? StParity : StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (tick) begin
               state_d   = StStop;
               bit_cnt_d = '0;
            end
         end
         StStop: begin
            if (tick) begin
               if (bit_cnt_q == LastStop) begin
                  bit_cnt_d = '0;
                  if (!Turbo) begin
                     state_d = StGuard;
                  end else if (accept) begin
                     // Back-to-back: next start bit follows with no idle cycle.
                     state_d = StStart;
                     data_d  = bus.in_data;
                     shift_d = bus.in_data;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StGuard: begin
            if (tick) begin
               state_d = StIdle;
            end
         end
`ifdef UART_TX_BREAK_EN
         StBreak: begin
            if (!brk) begin
               state_d = StGuard;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      // Disable aborts the frame outright; the line goes back to mark.
      if (!bus.en) begin
         state_d   = StIdle;
         bit_cnt_d = '0;
      end
   end

   // Line level and busy flag decoded from the current state.
   always_comb begin
      bus.out  = 1'b1;
      bus.busy = 1'b1;
      case (state_q)
         StIdle: begin
            bus.out  = !brk;
            bus.busy = 1'b0;
         end
         StStart:  bus.out = 1'b0;
         StData:   bus.out = shift_q[0];
         StParity: bus.out = parity_bit(PARITY, ^data_q);
         StStop:   bus.out = 1'b1;
         StGuard:  bus.out = 1'b1;
`ifdef UART_TX_BREAK_EN
         StBreak: begin
            bus.out  = !brk;
            bus.busy = 1'b0;
         end
`endif
         default:  bus.out = 1'b1;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         data_q    <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: three configurations share clock,
// reset and enable; expected line waveforms come from a bit-list frame model.
module tb_uart_tx_frame;

   localparam int unsigned Cpb = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       vld;
   logic       brk;
   logic [8:0] din;
   int         sel;
   int         total;
   int         bad;
   logic [8:0] words [0:3];

   logic o_out, o_busy, o_done, o_rdy;

   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_BITS(8)) if_par ();
   uart_tx_frame_if #(.DATA_BITS(7)) if_odd ();
   uart_tx_frame_if #(.DATA_BITS(8)) if_trb ();

   assign if_par.en       = en;
   assign if_par.in_data  = din[7:0];
   assign if_par.in_valid = vld && (sel == 0);
   assign if_odd.en       = en;
   assign if_odd.in_data  = din[6:0];
   assign if_odd.in_valid = vld && (sel == 1);
   assign if_trb.en       = en;
   assign if_trb.in_data  = din[7:0];
   assign if_trb.in_valid = vld && (sel == 2);
`ifdef UART_TX_BREAK_EN
   assign if_par.brk = brk && (sel == 0);
   assign if_odd.brk = 1'b0;
   assign if_trb.brk = 1'b0;
`endif

   uart_tx_frame #(
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(Cpb), .TURBO_FRAMES(0)
   ) u_par (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_par)
   );

   uart_tx_frame #(
      .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(Cpb), .TURBO_FRAMES(0)
   ) u_odd (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_odd)
   );

   uart_tx_frame #(
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(Cpb), .TURBO_FRAMES(1)
   ) u_trb (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_trb)
   );

   always_comb begin
      case (sel)
         1: begin
            o_out = if_odd.out; o_busy = if_odd.busy; o_done = if_odd.done; o_rdy = if_odd.in_ready;
         end
         2: begin
            o_out = if_trb.out; o_busy = if_trb.busy; o_done = if_trb.done; o_rdy = if_trb.in_ready;
         end
         default: begin
            o_out = if_par.out; o_busy = if_par.busy; o_done = if_par.done; o_rdy = if_par.in_ready;
         end
      endcase
   end

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s (sel %0d, t=%0t): got %b expected %b", tag, sel, $time, got, exp);
      end
   endtask

   // Sends words[0..n-1] to DUT s (chained when it runs turbo frames) and
   // checks every cycle against the frame model.
   task automatic send(input int s, input int n);
      int   nd, np, ns, nt, ones, last;
      logic fb [$];
      logic eo [$];
      logic ed [$];
      int   ef [$];
      logic [8:0] w;
      case (s)
         1:       begin nd = 7; np = 1; ns = 2; nt = 0; end
         2:       begin nd = 8; np = 0; ns = 1; nt = 1; end
         default: begin nd = 8; np = 2; ns = 1; nt = 0; end
      endcase
      for (int f = 0; f < n; f++) begin
         w = words[f];
         ones = 0;
         fb = {};
         fb.push_back(1'b0);
         for (int i = 0; i < nd; i++) begin
            fb.push_back(w[i]);
            ones += int'(w[i]);
         end
         if (np == 2) fb.push_back(ones % 2 == 1);
         if (np == 1) fb.push_back(ones % 2 == 0);
         for (int i = 0; i < ns; i++) fb.push_back(1'b1);
         last = fb.size() - 1;
         if (nt == 0) fb.push_back(1'b1);
         foreach (fb[b]) begin
            for (int k = 0; k < Cpb; k++) begin
               eo.push_back(fb[b]);
               ed.push_back((b == last) && (k == Cpb - 1));
               ef.push_back(f);
            end
         end
      end
      @(posedge clk); #1;
      sel = s; din = words[0]; vld = 1'b1;
      @(negedge clk);
      chk("ready_before", o_rdy, 1'b1);
      chk("out_before", o_out, 1'b1);
      chk("busy_before", o_busy, 1'b0);
      for (int j = 0; j < eo.size(); j++) begin
         @(posedge clk); #1;
         if (nt != 0 && ef[j] + 1 < n) begin
            vld = 1'b1;
            din = words[ef[j] + 1];
         end else begin
            din = 9'($urandom);
            vld = (nt != 0 && ed[j]) ? 1'b0 : 1'($urandom);
         end
         @(negedge clk);
         chk("out", o_out, eo[j]);
         chk("busy", o_busy, 1'b1);
         chk("done", o_done, ed[j]);
         chk("ready", o_rdy, (nt != 0) && ed[j]);
      end
      @(posedge clk); #1;
      vld = 1'b0;
      @(negedge clk);
      chk("busy_after", o_busy, 1'b0);
      chk("out_after", o_out, 1'b1);
      chk("ready_after", o_rdy, 1'b1);
      chk("done_after", o_done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; sel = 0; vld = 1'b0; brk = 1'b0; din = '0;
      en = 1'b1; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vld = 1'b1;
      @(negedge clk);
      chk("rst_ready", o_rdy, 1'b0);
      chk("rst_out", o_out, 1'b1);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1; vld = 1'b0;
      @(negedge clk);
      chk("ready_after_release", o_rdy, 1'b1);

      // Directed frames from the plan.
      words[0] = 9'h0A5; send(0, 1);
      words[0] = 9'h000; send(1, 1);
      words[0] = 9'h055; words[1] = 9'h00F; send(2, 2);

      // Random words across all three configurations.
      for (int r = 0; r < 9; r++) begin
         for (int i = 0; i < 4; i++) words[i] = 9'($urandom);
         send(r % 3, (r % 3 == 2) ? 3 : 1);
      end

      // Reset during data bit 3 (0xA5: bit 3 is 0), then a clean frame.
      @(posedge clk); #1;
      sel = 0; din = 9'h0A5; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      @(negedge clk);
      chk("abort_bit3", o_out, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ready_in_rst", o_rdy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_out", o_out, 1'b1);
      chk("abort_busy", o_busy, 1'b0);
      chk("abort_done", o_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      words[0] = 9'h03C; send(0, 1);

      // Enable dropped mid-frame on the turbo instance.
      @(posedge clk); #1;
      sel = 2; din = 9'h0FF; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      @(negedge clk);
      chk("en_mid_busy", o_busy, 1'b1);
      @(posedge clk); #1;
      en = 1'b0; vld = 1'b1;
      @(negedge clk);
      chk("en_low_ready", o_rdy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("en_low_out", o_out, 1'b1);
         chk("en_low_busy", o_busy, 1'b0);
         chk("en_low_rdy", o_rdy, 1'b0);
      end
      @(posedge clk); #1;
      en = 1'b1; vld = 1'b0;
      @(negedge clk);
      chk("en_back_ready", o_rdy, 1'b1);
      words[0] = 9'h0C3; send(2, 1);

`ifdef UART_TX_BREAK_EN
      // Break held 20 cycles in idle, then a guard period before ready.
      @(posedge clk); #1;
      sel = 0; vld = 1'b1; brk = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("brk_out", o_out, 1'b0);
         chk("brk_ready", o_rdy, 1'b0);
         @(posedge clk); #1;
      end
      brk = 1'b0;
      for (int i = 0; i < Cpb; i++) begin
         @(negedge clk);
         chk("brk_guard_out", o_out, 1'b1);
         chk("brk_guard_ready", o_rdy, 1'b0);
         @(posedge clk); #1;
      end
      vld = 1'b0;
      @(negedge clk);
      chk("brk_ready_back", o_rdy, 1'b1);
      words[0] = 9'h081; send(0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
